// File: rtl/branch_resolve_pkg.sv
// Shared defaults and helpers for the branch resolution slice.
package branch_resolve_pkg;

  // Project defaults for the predictor interface widths and queue capacity.
  localparam int unsigned W_BRID    = 2;
  localparam int unsigned W_ADDR    = 32;
  localparam int unsigned BRQ_DEPTH = 4;

  // A branch mispredicted when its predicted and actual directions differ.
  function automatic logic brq_is_miss(input logic pred, input logic taken);
    return pred ^ taken;
  endfunction

endpackage

// File: rtl/branch_queue.sv
// Parameterised circular FIFO holding in-flight branch predictions.
// Clear has priority over push and pop; a push while full is dropped.
module branch_queue #(
  parameter int unsigned W_DATA = 35,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W_DATA-1:0]          wr_data,
  output logic [W_DATA-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned W_PTR = $clog2(DEPTH);
  localparam int unsigned W_CNT = W_PTR + 1;

  logic [W_DATA-1:0] mem [DEPTH];
  logic [W_PTR-1:0]  head;
  logic [W_PTR-1:0]  tail;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == W_CNT'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign rd_data = mem[head];

  // Entry storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail] <= wr_data;
    end
  end

  // Pointer and occupancy update; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        tail <= tail + W_PTR'(1);
      end
      if (do_pop) begin
        head <= head + W_PTR'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + W_CNT'(1);
        2'b01:   count <= count - W_CNT'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-side branch resolution: returns training updates to the
// predictor and raises flush/redirect on a mispredict.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int unsigned W_BRID = branch_resolve_pkg::W_BRID,
  parameter int unsigned W_ADDR = branch_resolve_pkg::W_ADDR,
  parameter int unsigned DEPTH  = branch_resolve_pkg::BRQ_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pred_i,
  input  logic [W_BRID-1:0] pred_id_i,
  input  logic [W_ADDR-1:0] alt_pc_i,
  output logic              stall_o,
  input  logic              resolve_i,
  input  logic              taken_i,
  output logic              v_o,
  output logic              branch_o,
  output logic [W_BRID-1:0] branch_id_o,
  output logic              flush_o,
  output logic [W_ADDR-1:0] redirect_pc_o,
  output logic              err_o
);

  localparam int unsigned W_DATA = 1 + W_BRID + W_ADDR;

  logic [W_DATA-1:0]      q_rd_data;
  logic [$clog2(DEPTH):0] q_count;
  logic                   q_full;
  logic                   q_empty;
  logic                   head_pred;
  logic [W_BRID-1:0]      head_id;
  logic [W_ADDR-1:0]      head_alt;
  logic                   resolve_ok;
  logic                   miss;

  assign head_pred  = q_rd_data[W_DATA-1];
  assign head_id    = q_rd_data[W_ADDR +: W_BRID];
  assign head_alt   = q_rd_data[W_ADDR-1:0];
  assign resolve_ok = resolve_i & (q_count != '0);
  assign miss       = resolve_ok & brq_is_miss(head_pred, taken_i);
  assign stall_o    = q_full;

  // A mispredict clears the queue, which also discards any same-cycle push.
  branch_queue #(
    .W_DATA (W_DATA),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push    (push_i),
    .pop     (resolve_ok),
    .clear   (miss),
    .wr_data ({pred_i, pred_id_i, alt_pc_i}),
    .rd_data (q_rd_data),
    .count   (q_count),
    .full    (q_full),
    .empty   (q_empty)
  );

  // Registered training update and redirect; v_o/flush_o pulse per resolve.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_o           <= 1'b0;
      branch_o      <= 1'b0;
      branch_id_o   <= '0;
      flush_o       <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      v_o     <= resolve_ok;
      flush_o <= miss;
      if (resolve_ok) begin
        branch_o    <= taken_i;
        branch_id_o <= head_id;
      end
      if (miss) begin
        redirect_pc_o <= head_alt;
      end
    end
  end

  // Sticky error for a resolve with nothing outstanding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_o <= 1'b0;
    end else if (resolve_i & q_empty) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push_i = 1'b0;
  logic        pred_i = 1'b0;
  logic [1:0]  pred_id_i = '0;
  logic [31:0] alt_pc_i = '0;
  logic        stall_o;
  logic        resolve_i = 1'b0;
  logic        taken_i = 1'b0;
  logic        v_o;
  logic        branch_o;
  logic [1:0]  branch_id_o;
  logic        flush_o;
  logic [31:0] redirect_pc_o;
  logic        err_o;

  int unsigned checks = 0;
  int unsigned failures = 0;

  branch_resolve #(
    .W_BRID (2),
    .W_ADDR (32),
    .DEPTH  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .push_i        (push_i),
    .pred_i        (pred_i),
    .pred_id_i     (pred_id_i),
    .alt_pc_i      (alt_pc_i),
    .stall_o       (stall_o),
    .resolve_i     (resolve_i),
    .taken_i       (taken_i),
    .v_o           (v_o),
    .branch_o      (branch_o),
    .branch_id_o   (branch_id_o),
    .flush_o       (flush_o),
    .redirect_pc_o (redirect_pc_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic p, input logic pr, input logic [1:0] id, input logic [31:0] alt);
    push_i    = p;
    pred_i    = pr;
    pred_id_i = id;
    alt_pc_i  = alt;
  endtask

  task automatic set_res(input logic r, input logic t);
    resolve_i = r;
    taken_i   = t;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_v"}, 64'(v_o), 64'd0);
    check({tag, "_flush"}, 64'(flush_o), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_v", 64'(v_o), 64'd0);
    check("rst_branch", 64'(branch_o), 64'd0);
    check("rst_id", 64'(branch_id_o), 64'd0);
    check("rst_flush", 64'(flush_o), 64'd0);
    check("rst_redir", 64'(redirect_pc_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_stall", 64'(stall_o), 64'd0);
    #2 reset = 1'b1;

    // Single push then hit resolve
    set_push(1, 1, 2'b11, 32'h100); tick();
    set_push(0, 0, 2'b00, 32'h0); set_res(1, 1); tick();
    set_res(0, 0);
    check("t1_v", 64'(v_o), 64'd1);
    check("t1_branch", 64'(branch_o), 64'd1);
    check("t1_id", 64'(branch_id_o), 64'd3);
    check("t1_flush", 64'(flush_o), 64'd0);
    check("t1_count", 64'(dut.u_queue.count), 64'd0);
    tick();
    check_idle("t1_pulse");

    // Mispredict on the older of two entries
    set_push(1, 1, 2'b10, 32'h200); tick();
    set_push(1, 0, 2'b01, 32'h300); tick();
    set_push(0, 0, 2'b00, 32'h0); set_res(1, 0); tick();
    set_res(0, 0);
    check("t2_v", 64'(v_o), 64'd1);
    check("t2_branch", 64'(branch_o), 64'd0);
    check("t2_flush", 64'(flush_o), 64'd1);
    check("t2_redir", 64'(redirect_pc_o), 64'h200);
    check("t2_id", 64'(branch_id_o), 64'd2);
    check("t2_count", 64'(dut.u_queue.count), 64'd0);
    tick();
    check_idle("t2_after");
    tick();
    check_idle("t2_never");
    check("t2_err", 64'(err_o), 64'd0);

    // Fill to capacity, refuse a fifth push, drain in order
    for (int i = 0; i < 4; i++) begin
      set_push(1, i[1], 2'(i), 32'h1000 + 32'(i)); tick();
    end
    check("t3_stall", 64'(stall_o), 64'd1);
    check("t3_count4", 64'(dut.u_queue.count), 64'd4);
    set_push(1, 1, 2'b10, 32'hDEAD); tick();
    set_push(0, 0, 2'b00, 32'h0);
    check("t3_count_full", 64'(dut.u_queue.count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      set_res(1, i[1]); tick();
      check($sformatf("t3_v%0d", i), 64'(v_o), 64'd1);
      check($sformatf("t3_id%0d", i), 64'(branch_id_o), 64'(i));
      check($sformatf("t3_flush%0d", i), 64'(flush_o), 64'd0);
      check($sformatf("t3_stall%0d", i), 64'(stall_o), 64'd0);
    end
    set_res(0, 0); tick();
    check("t3_count0", 64'(dut.u_queue.count), 64'd0);
    check_idle("t3_end");

    // Simultaneous push with hit, then with mispredict, then redirect-cycle push
    set_push(1, 1, 2'b11, 32'h400); tick();
    set_push(1, 0, 2'b01, 32'h500); set_res(1, 1); tick();
    check("t4_hit_v", 64'(v_o), 64'd1);
    check("t4_hit_id", 64'(branch_id_o), 64'd3);
    check("t4_hit_flush", 64'(flush_o), 64'd0);
    check("t4_hit_count", 64'(dut.u_queue.count), 64'd1);
    set_push(1, 1, 2'b10, 32'h600); set_res(1, 1); tick();
    check("t4_miss_flush", 64'(flush_o), 64'd1);
    check("t4_miss_redir", 64'(redirect_pc_o), 64'h500);
    check("t4_miss_id", 64'(branch_id_o), 64'd1);
    check("t4_miss_branch", 64'(branch_o), 64'd1);
    check("t4_miss_count", 64'(dut.u_queue.count), 64'd0);
    set_push(1, 0, 2'b00, 32'h700); set_res(0, 0); tick();
    set_push(0, 0, 2'b00, 32'h0);
    check("t4_redir_push_count", 64'(dut.u_queue.count), 64'd1);
    set_res(1, 0); tick();
    set_res(0, 0);
    check("t4_new_v", 64'(v_o), 64'd1);
    check("t4_new_id", 64'(branch_id_o), 64'd0);
    check("t4_new_flush", 64'(flush_o), 64'd0);
    check("t4_new_count", 64'(dut.u_queue.count), 64'd0);

    // Resolve while empty
    set_res(1, 1); tick();
    set_res(0, 0);
    check("t5_v", 64'(v_o), 64'd0);
    check("t5_err", 64'(err_o), 64'd1);
    tick(); tick();
    check("t5_err_sticky", 64'(err_o), 64'd1);

    // Asynchronous reset with entries queued and a resolve pending
    for (int i = 0; i < 3; i++) begin
      set_push(1, 1, 2'b11, 32'h800 + 32'(i)); tick();
    end
    set_push(0, 0, 2'b00, 32'h0);
    set_res(1, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_v", 64'(v_o), 64'd0);
    check("t6_branch", 64'(branch_o), 64'd0);
    check("t6_id", 64'(branch_id_o), 64'd0);
    check("t6_flush", 64'(flush_o), 64'd0);
    check("t6_redir", 64'(redirect_pc_o), 64'd0);
    check("t6_err", 64'(err_o), 64'd0);
    check("t6_count", 64'(dut.u_queue.count), 64'd0);
    set_res(0, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_post_v%0d", i), 64'(v_o), 64'd0);
    end
    check("t6_post_err", 64'(err_o), 64'd0);
    check("t6_post_stall", 64'(stall_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Execute-side counterpart of the fetch-stage branch predictor. Holds every in-flight prediction (taken bit, 2-bit counter snapshot `pred_id`, alternate PC) in program order. When execute resolves the oldest branch, the block returns the outcome and snapshot to the predictor as its training update. On a mispredict it raises a flush and redirect toward fetch.

## Interface
- `W_BRID`, 2: width of the predictor counter snapshot; from `params.v`.
- `W_ADDR`, 32: instruction address width; from `params.v`.
- `DEPTH`, 4: in-flight branch capacity; power of two, at least 2.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `push_i` in 1: fetch issues a predicted branch this cycle.
- `pred_i` in 1: predicted direction (1 = taken).
- `pred_id_i` in W_BRID: counter snapshot sent with the prediction.
- `alt_pc_i` in W_ADDR: PC of the path *not* predicted.
- `stall_o` out 1: queue full; fetch must not push.
- `resolve_i` in 1: execute resolves the oldest outstanding branch.
- `taken_i` in 1: actual direction of that branch.
- `v_o` out 1: training update valid, to predictor `v_i`.
- `branch_o` out 1: actual outcome, to predictor `branch_i`.
- `branch_id_o` out W_BRID: stored snapshot, to predictor `branch_id_i`.
- `flush_o` out 1: mispredict; squash all younger work.
- `redirect_pc_o` out W_ADDR: fetch target when `flush_o` is high.
- `err_o` out 1: sticky; a resolve arrived while the queue was empty.

## Operation
- **Storage:** circular FIFO with `DEPTH` entries of {pred, pred_id, alt_pc}.
  - Head and tail pointers are `clog2(DEPTH)` bits and wrap naturally.
  - Occupancy `count` is `clog2(DEPTH)+1` bits.
- **Push:** when `push_i & ~stall_o`, write the entry at tail, then advance tail.
- **Push while full:** the entry is dropped and `count` is unchanged. This is a protocol violation; fetch gates on `stall_o`.
- **Resolve:** when `resolve_i & (count != 0)`, read the head entry.
  - `miss = pred ^ taken_i`.
  - Register `v_o = 1`, `branch_o = taken_i`, `branch_id_o = pred_id` (snapshot returned unmodified).
  - Pop the head.
- **Mispredict** (`miss = 1`):
  - Register `flush_o = 1` and `redirect_pc_o = alt_pc`.
  - Clear the whole queue: head = tail = 0, count = 0. All remaining entries are younger and wrong-path.
- **Resolve while empty:** no pop, `v_o` stays 0, `err_o` is set. `err_o` clears only on reset.
- **Push and resolve in the same cycle:**
  - Hit: both take effect; `count` is unchanged.
  - Mispredict: the same-cycle push is discarded, because it is younger.
  - Push while full with a same-cycle resolve: still refused, since `stall_o` is based on registered `count`.
- **`stall_o`:** `count == DEPTH`, combinational from registered state.
- **Consistency:** `branch_id_o[1]` XOR `branch_o` equals `flush_o` whenever `v_o` is high. This holds because the predictor drives `pred_i = pred_id_i[1]` when it is not stalled.

## Timing
- **Reset values:** `v_o`, `branch_o`, `branch_id_o`, `flush_o`, `redirect_pc_o`, `err_o` all 0. Pointers and `count` 0; `stall_o` 0.
- **Reset mid-operation:** everything is cleared asynchronously and no update is emitted.
- **Resolve latency:** 1 cycle from `resolve_i` to `v_o`/`flush_o`. Both are single-cycle pulses per resolve.
- **Back-to-back resolves:** one update per cycle.
- **Push to resolve:** a pushed entry can be resolved from the cycle after the push.
- **Redirect after mispredict:** `flush_o` and `redirect_pc_o` are valid in the same cycle. Fetch acts on them in that cycle; a push in that same cycle is accepted into the now-empty queue as the first correct-path branch.

## Structure
- `W_BRID` and `W_ADDR` stay in `include/params.v`. Add `BRQ_DEPTH` there as the project default.
- One sub-module: `branch_queue`, a parameterised FIFO.
  - Inputs: push, pop, clear.
  - Outputs: head data, count, full, empty.
- `branch_resolve` holds the miss logic, output registers and error flag.

## Test plan
- Reset, push {pred=1, id=2'b11, alt=0x100}, resolve taken=1:
  - next cycle: `v_o=1`, `branch_o=1`, `branch_id_o=2'b11`, `flush_o=0`;
  - afterwards: `count=0`.
- Push {pred=1, id=2'b10, alt=0x200}, push {pred=0, id=2'b01, alt=0x300}, resolve taken=0 on the first:
  - `flush_o=1`, `redirect_pc_o=0x200`, `branch_id_o=2'b10`;
  - queue empty afterwards, and the second entry is never reported.
- Fill 4 entries → `stall_o=1`. A fifth push is ignored. Four hit resolves return the ids in push order; the pointers wrap, and `stall_o` drops after the first pop.
- Hit resolve with a simultaneous push → count unchanged. Mispredict resolve with a simultaneous push → count 0, and the pushed entry is discarded.
- Resolve while empty → `v_o=0`, `err_o=1`, and `err_o` stays 1 until reset.
- Assert `reset` low with 3 entries queued and a resolve pending → all outputs 0 immediately, with no `v_o` pulse after release.
